// File: rtl/tl_phase_ctrl.sv
// tl_phase_ctrl: tick-timed green/yellow/all-red sequencer for N approaches,
// with a latched pedestrian walk phase and a flashing-yellow fallback.
module tl_phase_ctrl #(
    parameter int NUM_APPROACH = 4,
    parameter int TICK_DIV     = 100000000,
    parameter int T_GREEN      = 7,
    parameter int T_YELLOW     = 2,
    parameter int T_ALLRED     = 1,
    parameter int T_PED        = 5
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      en,
    input  logic                      ped_req,
    input  logic                      flash_mode,
    output logic [3*NUM_APPROACH-1:0] lights,
    output logic                      walk,
    output logic                      ped_ack,
    output logic [2:0]                phase
);
    localparam int             PW     = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0]  PS_MAX = PW'(TICK_DIV - 1);
    localparam logic [2:0]     LAST   = 3'(NUM_APPROACH - 1);
    localparam logic [15:0]    TM_G   = 16'(T_GREEN);
    localparam logic [15:0]    TM_Y   = 16'(T_YELLOW);
    localparam logic [15:0]    TM_AR  = 16'(T_ALLRED);
    localparam logic [15:0]    TM_P   = 16'(T_PED);
    localparam logic [2:0] S_GREEN  = 3'd0;
    localparam logic [2:0] S_YELLOW = 3'd1;
    localparam logic [2:0] S_ALLRED = 3'd2;
    localparam logic [2:0] S_WALK   = 3'd3;
    localparam logic [2:0] S_FLASH  = 3'd4;

    logic [2:0]    state, state_nx, phase_nx;
    logic [PW-1:0] presc;
    logic [15:0]   timer, timer_nx;
    logic          ped_pending, pend_nx, flash_on, flash_nx, ack_nx;
    logic          tick, expire;

    assign tick   = presc == PS_MAX;
    assign expire = tick && timer == 16'd1;

    // A request on the deciding edge itself counts, hence pend_nx feeds the WALK choice.
    always_comb begin
        state_nx = state;
        phase_nx = phase;
        timer_nx = tick ? timer - 16'd1 : timer;
        flash_nx = flash_on;
        pend_nx  = ped_pending | ped_req;
        ack_nx   = 1'b0;
        case (state)
            S_GREEN: if (expire) begin
                state_nx = S_YELLOW;
                timer_nx = TM_Y;
            end
            S_YELLOW: if (expire) begin
                state_nx = S_ALLRED;
                timer_nx = TM_AR;
            end
            S_ALLRED, S_WALK: if (expire) begin
                if (flash_mode) begin
                    state_nx = S_FLASH;
                    timer_nx = 16'd1;
                    flash_nx = 1'b1;
                end else if (state == S_ALLRED && phase != LAST) begin
                    state_nx = S_GREEN;
                    phase_nx = phase + 3'd1;
                    timer_nx = TM_G;
                end else if (state == S_ALLRED && pend_nx) begin
                    state_nx = S_WALK;
                    timer_nx = TM_P;
                    pend_nx  = 1'b0;
                    ack_nx   = 1'b1;
                end else begin
                    state_nx = S_GREEN;
                    phase_nx = 3'd0;
                    timer_nx = TM_G;
                end
            end
            S_FLASH: if (tick) begin
                timer_nx = flash_mode ? 16'd1 : TM_AR;
                flash_nx = ~flash_on;
                state_nx = flash_mode ? S_FLASH : S_ALLRED;
                phase_nx = flash_mode ? phase : LAST;
            end
            default: begin
                state_nx = S_GREEN;
                phase_nx = 3'd0;
                timer_nx = TM_G;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_GREEN;
            phase       <= 3'd0;
            timer       <= TM_G;
            presc       <= '0;
            ped_pending <= 1'b0;
            flash_on    <= 1'b0;
            ped_ack     <= 1'b0;
        end else begin
            ped_ack <= en & ack_nx;
            if (en) begin
                presc       <= tick ? '0 : presc + PW'(1);
                state       <= state_nx;
                phase       <= phase_nx;
                timer       <= timer_nx;
                ped_pending <= pend_nx;
                flash_on    <= flash_nx;
            end
        end
    end

    for (genvar i = 0; i < NUM_APPROACH; i++) begin : g_lamp
        assign lights[3*i +: 3] = state == S_FLASH ? {1'b0, flash_on, 1'b0} :
                                  phase != 3'(i)   ? 3'b100 :
                                  state == S_GREEN ? 3'b001 :
                                  state == S_YELLOW ? 3'b010 : 3'b100;
    end

    assign walk = state == S_WALK;
endmodule

// File: tb/tb_tl_phase_ctrl.sv
// tb_tl_phase_ctrl: directed-sequence bench for tl_phase_ctrl with hand-derived lamp timelines.
module tb_tl_phase_ctrl;
    localparam logic [8:0] G0   = 9'b100_100_001;
    localparam logic [8:0] Y0   = 9'b100_100_010;
    localparam logic [8:0] G1   = 9'b100_001_100;
    localparam logic [8:0] Y1   = 9'b100_010_100;
    localparam logic [8:0] G2   = 9'b001_100_100;
    localparam logic [8:0] Y2   = 9'b010_100_100;
    localparam logic [8:0] AR   = 9'b100_100_100;
    localparam logic [8:0] FON  = 9'b010_010_010;
    localparam logic [8:0] FOFF = 9'b000_000_000;

    logic       clk = 1'b0;
    logic       rst_n, en, ped_req, flash_mode;
    logic [8:0] lights;
    logic       walk, ped_ack;
    logic [2:0] phase;
    int         checks = 0;
    int         passes = 0;

    tl_phase_ctrl #(
        .NUM_APPROACH(3), .TICK_DIV(4), .T_GREEN(5), .T_YELLOW(2), .T_ALLRED(1), .T_PED(3)
    ) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .ped_req(ped_req), .flash_mode(flash_mode),
        .lights(lights), .walk(walk), .ped_ack(ped_ack), .phase(phase)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    endtask

    // Checks n consecutive negedge samples; ack is expected only on the first one.
    task automatic hold(input string tag, input logic [8:0] el, input logic ew, input logic ea, input int n);
        for (int k = 0; k < n; k++) begin
            chk(tag, 32'(lights), 32'(el));
            chk({tag, "_walk"}, 32'(walk), 32'(ew));
            chk({tag, "_ack"}, 32'(ped_ack), (k == 0) ? 32'(ea) : 32'd0);
            @(negedge clk);
        end
    endtask

    task automatic round(input string tag);
        hold({tag, "_g0"}, G0, 0, 0, 20);
        hold({tag, "_y0"}, Y0, 0, 0, 8);
        hold({tag, "_ar0"}, AR, 0, 0, 4);
        hold({tag, "_g1"}, G1, 0, 0, 20);
        hold({tag, "_y1"}, Y1, 0, 0, 8);
        hold({tag, "_ar1"}, AR, 0, 0, 4);
        hold({tag, "_g2"}, G2, 0, 0, 20);
        hold({tag, "_y2"}, Y2, 0, 0, 8);
        hold({tag, "_ar2"}, AR, 0, 0, 4);
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b1; ped_req = 1'b0; flash_mode = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_lights", 32'(lights), 32'(G0));
        chk("rst_phase", 32'(phase), 32'd0);
        chk("rst_walk", 32'(walk), 32'd0);
        chk("rst_ack", 32'(ped_ack), 32'd0);
        rst_n = 1'b1;
        hold("first_g0", G0, 0, 0, 20);
        hold("first_y0", Y0, 0, 0, 8);
        hold("first_ar0", AR, 0, 0, 4);
        chk("first_phase1", 32'(phase), 32'd1);
        hold("first_g1", G1, 0, 0, 20);
        hold("first_y1", Y1, 0, 0, 8);
        hold("first_ar1", AR, 0, 0, 4);
        chk("first_phase2", 32'(phase), 32'd2);
        hold("first_g2", G2, 0, 0, 20);
        hold("first_y2", Y2, 0, 0, 8);
        hold("first_ar2", AR, 0, 0, 4);
        chk("wrap_phase0", 32'(phase), 32'd0);
        hold("ped_g0", G0, 0, 0, 20);
        hold("ped_y0", Y0, 0, 0, 8);
        hold("ped_ar0", AR, 0, 0, 4);
        hold("ped_g1a", G1, 0, 0, 5);
        ped_req = 1'b1;
        hold("ped_g1b", G1, 0, 0, 1);
        ped_req = 1'b0;
        hold("ped_g1c", G1, 0, 0, 14);
        hold("ped_y1", Y1, 0, 0, 8);
        hold("ped_ar1", AR, 0, 0, 4);
        hold("ped_g2", G2, 0, 0, 20);
        hold("ped_y2", Y2, 0, 0, 8);
        hold("ped_ar2", AR, 0, 0, 4);
        hold("ped_walk", AR, 1, 1, 12);
        chk("post_walk_phase", 32'(phase), 32'd0);
        hold("fl_g0a", G0, 0, 0, 3);
        flash_mode = 1'b1;
        hold("fl_g0b", G0, 0, 0, 17);
        hold("fl_y0", Y0, 0, 0, 8);
        hold("fl_ar0", AR, 0, 0, 4);
        hold("fl_on1", FON, 0, 0, 4);
        hold("fl_off1", FOFF, 0, 0, 4);
        hold("fl_on2", FON, 0, 0, 4);
        flash_mode = 1'b0;
        hold("fl_off2", FOFF, 0, 0, 4);
        chk("fl_exit_phase", 32'(phase), 32'd2);
        hold("fl_ar2", AR, 0, 0, 4);
        hold("en_g0", G0, 0, 0, 20);
        hold("en_y0", Y0, 0, 0, 8);
        hold("en_ar0", AR, 0, 0, 4);
        hold("en_g1a", G1, 0, 0, 5);
        en = 1'b0;
        hold("en_g1_frozen", G1, 0, 0, 10);
        en = 1'b1;
        hold("en_g1b", G1, 0, 0, 15);
        hold("en_y1", Y1, 0, 0, 8);
        hold("en_ar1", AR, 0, 0, 4);
        hold("en_g2", G2, 0, 0, 20);
        hold("rs_y2a", Y2, 0, 0, 3);
        ped_req = 1'b1;
        hold("rs_y2b", Y2, 0, 0, 1);
        ped_req = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("rs_async_lights", 32'(lights), 32'(G0));
        chk("rs_async_phase", 32'(phase), 32'd0);
        chk("rs_async_walk", 32'(walk), 32'd0);
        chk("rs_async_ack", 32'(ped_ack), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        round("lost");
        hold("late_g0", G0, 0, 0, 20);
        hold("late_y0", Y0, 0, 0, 8);
        hold("late_ar0", AR, 0, 0, 4);
        hold("late_g1", G1, 0, 0, 20);
        hold("late_y1", Y1, 0, 0, 8);
        hold("late_ar1", AR, 0, 0, 4);
        hold("late_g2", G2, 0, 0, 20);
        hold("late_y2", Y2, 0, 0, 8);
        hold("late_ar2a", AR, 0, 0, 3);
        ped_req = 1'b1;
        hold("late_ar2b", AR, 0, 0, 1);
        ped_req = 1'b0;
        hold("late_walk", AR, 1, 1, 12);
        hold("late_g0_after", G0, 0, 0, 20);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
